// File: rtl/mem_fu_pkg.sv
// Shared types for the memory functional unit: issue packet, CDB broadcast,
// load/store op encodings and ROB tag width.
package mem_fu_pkg;

  localparam int DATA_W        = 32;
  localparam int ROB_TAG_WIDTH = 4;

  // funct3 encodings; loads and stores share the width field
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic {
    IS_LOAD  = 1'b0,
    IS_STORE = 1'b1
  } ls_e;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc_rdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_t;

  typedef struct packed {
    logic                     valid;
    logic [2:0]               mem_op;
    ls_e                      ls;
    logic [DATA_W-1:0]        rs1_v;
    logic [DATA_W-1:0]        rs2_v;
    logic [DATA_W-1:0]        offset;
    logic [ROB_TAG_WIDTH-1:0] rob_tag;
    logic [DATA_W-1:0]        pc;
    rvfi_t                    rvfi;
  } fu_pkt_t;

  typedef struct packed {
    logic                     valid;
    logic [ROB_TAG_WIDTH-1:0] rob_tag;
    logic [DATA_W-1:0]        data;
    rvfi_t                    rvfi;
  } cdb_t;

endpackage

// File: rtl/mem_fu_align.sv
// Byte-lane logic: access mask, store-data lane shift, load extraction and
// sign/zero extension. Purely combinational so a store buffer can reuse it.
module mem_fu_align
  import mem_fu_pkg::*;
(
  input  logic [2:0]        i_mem_op,
  input  logic [1:0]        i_offset,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic [DATA_W-1:0] i_load_raw,
  output logic [3:0]        o_mask,
  output logic [DATA_W-1:0] o_store_data,
  output logic [DATA_W-1:0] o_load_data
);

  function automatic logic [DATA_W-1:0] load_format(input logic [2:0]        op,
                                                     input logic [DATA_W-1:0] lane);
    case (op)
      LB:      return {{24{lane[7]}}, lane[7:0]};
      LBU:     return {24'b0, lane[7:0]};
      LH:      return {{16{lane[15]}}, lane[15:0]};
      LHU:     return {16'b0, lane[15:0]};
      default: return lane;
    endcase
  endfunction

  logic [4:0] w_shamt;
  assign w_shamt = {i_offset, 3'b000};

  always_comb begin
    o_mask = 4'hF;
    case (i_mem_op[1:0])
      2'b00:   o_mask = 4'b0001 << i_offset;
      2'b01:   o_mask = 4'b0011 << i_offset;
      default: o_mask = 4'hF;
    endcase
  end

  assign o_store_data = i_store_data << w_shamt;
  assign o_load_data  = load_format(i_mem_op, i_load_raw >> w_shamt);

endmodule

// File: rtl/mem_fu.sv
// Memory functional unit: accepts one load/store, drives a single-outstanding
// data-memory port, and broadcasts the result on the CDB with req/ack.
module mem_fu
  import mem_fu_pkg::*;
#(
  parameter int XLEN      = DATA_W,
  parameter int ROB_TAG_W = ROB_TAG_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  fu_pkt_t              i_mem_pkt,
  output logic                 o_backpressure,
  input  logic [ROB_TAG_W-1:0] i_rob_head_tag,
  output logic [XLEN-1:0]      o_dmem_addr,
  output logic [3:0]           o_dmem_rmask,
  output logic [3:0]           o_dmem_wmask,
  output logic [XLEN-1:0]      o_dmem_wdata,
  input  logic [XLEN-1:0]      i_dmem_rdata,
  input  logic                 i_dmem_resp,
  output logic                 o_cdb_req,
  input  logic                 i_cdb_ack,
  output cdb_t                 o_cdb_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_ST_WAIT, S_REQ, S_RESP_WAIT, S_RESULT
  } state_e;

  state_e          r_state, w_state_nxt;
  fu_pkt_t         r_pkt;
  logic [XLEN-1:0] r_addr;
  logic            r_drop;
  cdb_t            r_result;

  logic            w_accept, w_is_store, w_in_req;
  logic [3:0]      w_mask;
  logic [XLEN-1:0] w_aligned, w_wdata, w_ldata;
  logic            w_unused;

  assign w_accept   = (r_state == S_IDLE) && i_mem_pkt.valid && !i_flush;
  assign w_is_store = (r_pkt.ls == IS_STORE);
  assign w_in_req   = (r_state == S_REQ);
  assign w_aligned  = {r_addr[XLEN-1:2], 2'b00};
  // valid/rs1/offset are fully consumed at accept time
  assign w_unused   = ^{r_pkt.valid, r_pkt.rs1_v, r_pkt.offset};

  mem_fu_align u_align (
    .i_mem_op     (r_pkt.mem_op),
    .i_offset     (r_addr[1:0]),
    .i_store_data (r_pkt.rs2_v),
    .i_load_raw   (i_dmem_rdata),
    .o_mask       (w_mask),
    .o_store_data (w_wdata),
    .o_load_data  (w_ldata)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_accept)
          w_state_nxt = (i_mem_pkt.ls == IS_LOAD || i_mem_pkt.rob_tag == i_rob_head_tag)
                        ? S_REQ : S_ST_WAIT;
      S_ST_WAIT:
        if (i_flush)                            w_state_nxt = S_IDLE;
        else if (r_pkt.rob_tag == i_rob_head_tag) w_state_nxt = S_REQ;
      S_REQ:
        w_state_nxt = S_RESP_WAIT;
      // an issued request cannot be cancelled; squash only once it returns
      S_RESP_WAIT:
        if (i_dmem_resp) w_state_nxt = (r_drop || i_flush) ? S_IDLE : S_RESULT;
      S_RESULT:
        if (i_flush || i_cdb_ack) w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_pkt    <= '0;
      r_addr   <= '0;
      r_drop   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pkt  <= i_mem_pkt;
        r_addr <= i_mem_pkt.rs1_v + i_mem_pkt.offset;
      end
      if (w_state_nxt == S_IDLE)
        r_drop <= 1'b0;
      else if (i_flush && (r_state == S_REQ || r_state == S_RESP_WAIT))
        r_drop <= 1'b1;
      if (r_state == S_RESP_WAIT && i_dmem_resp) begin
        r_result.valid          <= 1'b1;
        r_result.rob_tag        <= r_pkt.rob_tag;
        r_result.data           <= w_is_store ? '0 : w_ldata;
        r_result.rvfi           <= r_pkt.rvfi;
        r_result.rvfi.pc_rdata  <= r_pkt.pc;
        r_result.rvfi.mem_addr  <= w_aligned;
        r_result.rvfi.mem_rmask <= w_is_store ? 4'b0 : w_mask;
        r_result.rvfi.mem_wmask <= w_is_store ? w_mask : 4'b0;
        r_result.rvfi.mem_rdata <= w_is_store ? '0 : i_dmem_rdata;
        r_result.rvfi.mem_wdata <= w_is_store ? w_wdata : '0;
      end
    end
  end

  assign o_backpressure = (r_state != S_IDLE);
  assign o_dmem_addr    = w_in_req ? w_aligned : '0;
  assign o_dmem_rmask   = (w_in_req && !w_is_store) ? w_mask : 4'b0;
  assign o_dmem_wmask   = (w_in_req && w_is_store) ? w_mask : 4'b0;
  assign o_dmem_wdata   = (w_in_req && w_is_store) ? w_wdata : '0;
  assign o_cdb_req      = (r_state == S_RESULT);
  assign o_cdb_out      = o_cdb_req ? r_result : '0;

endmodule

// File: tb/tb_mem_fu.sv
// Directed bench for mem_fu: bench-driven memory responses, expected CDB
// results queued at issue and compared when the unit broadcasts.
module tb_mem_fu;
  import mem_fu_pkg::*;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data, addr, rdata, wdata, pc, insn;
    logic [3:0]  rmask, wmask;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, dmem_resp, cdb_ack;
  fu_pkt_t     pkt;
  logic [3:0]  head;
  logic [31:0] dmem_rdata;
  logic        bp, cdb_req;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_rmask, dmem_wmask;
  cdb_t        cdb_out;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  mem_fu dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_mem_pkt(pkt),
    .o_backpressure(bp), .i_rob_head_tag(head),
    .o_dmem_addr(dmem_addr), .o_dmem_rmask(dmem_rmask), .o_dmem_wmask(dmem_wmask),
    .o_dmem_wdata(dmem_wdata), .i_dmem_rdata(dmem_rdata), .i_dmem_resp(dmem_resp),
    .o_cdb_req(cdb_req), .i_cdb_ack(cdb_ack), .o_cdb_out(cdb_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pc_of(input logic [3:0] t);
    return 32'h0000_0400 + {26'b0, t, 2'b00};
  endfunction

  function automatic logic [31:0] insn_of(input logic [3:0] t);
    return 32'hA500_0000 | {28'b0, t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s: observed no event expected event within bound", tag);
  endtask

  task automatic present(input logic is_st, input logic [2:0] op, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] off, input logic [3:0] tag);
    pkt           = '0;
    pkt.valid     = 1'b1;
    pkt.mem_op    = op;
    pkt.ls        = is_st ? IS_STORE : IS_LOAD;
    pkt.rs1_v     = rs1;
    pkt.rs2_v     = rs2;
    pkt.offset    = off;
    pkt.rob_tag   = tag;
    pkt.pc        = pc_of(tag);
    pkt.rvfi.insn = insn_of(tag);
  endtask

  task automatic send(input logic is_st, input logic [2:0] op, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic [31:0] off, input logic [3:0] tag);
    present(is_st, op, rs1, rs2, off, tag);
    step();
    pkt.valid = 1'b0;
  endtask

  task automatic push(input logic [3:0] tag, input logic [31:0] data, input logic [31:0] addr,
                      input logic [3:0] rm, input logic [3:0] wm,
                      input logic [31:0] rd, input logic [31:0] wd);
    exp_t e;
    e.tag = tag; e.data = data; e.addr = addr; e.rmask = rm; e.wmask = wm;
    e.rdata = rd; e.wdata = wd; e.pc = pc_of(tag); e.insn = insn_of(tag);
    sb.push_back(e);
  endtask

  task automatic expect_req(input string tag, input logic [31:0] addr, input logic [3:0] rm,
                            input logic [3:0] wm, input logic [31:0] wd);
    int i = 0;
    while (dmem_rmask == 4'b0 && dmem_wmask == 4'b0 && i < 20) begin
      step();
      i++;
    end
    if (dmem_rmask == 4'b0 && dmem_wmask == 4'b0) begin
      timeout({tag, "_req"});
      return;
    end
    chk({tag, "_addr"},  dmem_addr, addr);
    chk({tag, "_rmask"}, 32'(dmem_rmask), 32'(rm));
    chk({tag, "_wmask"}, 32'(dmem_wmask), 32'(wm));
    chk({tag, "_wdata"}, dmem_wdata, wd);
    chk({tag, "_bp"},    32'(bp), 32'd1);
    step();
    chk({tag, "_one_req"}, 32'(dmem_rmask | dmem_wmask), 32'd0);
  endtask

  task automatic respond(input int lat, input logic [31:0] rd);
    repeat (lat - 1) step();
    dmem_rdata = rd;
    dmem_resp  = 1'b1;
    step();
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
  endtask

  task automatic take_cdb(input string tag, input int hold);
    exp_t e;
    int   i = 0;
    while (!cdb_req && i < 20) begin
      step();
      i++;
    end
    if (!cdb_req) begin
      timeout({tag, "_cdb"});
      return;
    end
    if (sb.size() == 0) begin
      timeout({tag, "_sb_empty"});
      return;
    end
    e = sb.pop_front();
    chk({tag, "_pc"},    cdb_out.rvfi.pc_rdata, e.pc);
    chk({tag, "_insn"},  cdb_out.rvfi.insn, e.insn);
    chk({tag, "_maddr"}, cdb_out.rvfi.mem_addr, e.addr);
    chk({tag, "_mrm"},   32'(cdb_out.rvfi.mem_rmask), 32'(e.rmask));
    chk({tag, "_mwm"},   32'(cdb_out.rvfi.mem_wmask), 32'(e.wmask));
    chk({tag, "_mrd"},   cdb_out.rvfi.mem_rdata, e.rdata);
    chk({tag, "_mwd"},   cdb_out.rvfi.mem_wdata, e.wdata);
    for (int h = 0; h <= hold; h++) begin
      chk({tag, "_req"},   32'(cdb_req), 32'd1);
      chk({tag, "_valid"}, 32'(cdb_out.valid), 32'd1);
      chk({tag, "_tag"},   32'(cdb_out.rob_tag), 32'(e.tag));
      chk({tag, "_data"},  cdb_out.data, e.data);
      chk({tag, "_bp"},    32'(bp), 32'd1);
      if (h < hold) step();
    end
    cdb_ack = 1'b1;
    step();
    cdb_ack = 1'b0;
    chk({tag, "_req_drop"}, 32'(cdb_req), 32'd0);
    chk({tag, "_bp_drop"},  32'(bp), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dmem_resp = 1'b0; cdb_ack = 1'b0;
    pkt = '0; head = '0; dmem_rdata = '0;
    repeat (3) step();
    chk("rst_bp",    32'(bp), 32'd0);
    chk("rst_req",   32'(cdb_req), 32'd0);
    chk("rst_addr",  dmem_addr, 32'd0);
    chk("rst_masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
    chk("rst_cdb",   cdb_out.data, 32'd0);
    rst = 1'b0;
    step();

    // word load, 3-cycle memory latency
    send(1'b0, LW, 32'h1000, 32'h0, 32'd8, 4'd1);
    push(4'd1, 32'hDEADBEEF, 32'h1008, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0);
    expect_req("lw", 32'h1008, 4'hF, 4'h0, 32'h0);
    respond(3, 32'hDEADBEEF);
    take_cdb("lw", 0);

    // sub-word loads
    send(1'b0, LB, 32'h1000, 32'h0, 32'd3, 4'd2);
    push(4'd2, 32'hFFFFFF80, 32'h1000, 4'h8, 4'h0, 32'h80112233, 32'h0);
    expect_req("lb", 32'h1000, 4'h8, 4'h0, 32'h0);
    respond(1, 32'h80112233);
    take_cdb("lb", 0);

    send(1'b0, LBU, 32'h1000, 32'h0, 32'd3, 4'd3);
    push(4'd3, 32'h00000080, 32'h1000, 4'h8, 4'h0, 32'h80112233, 32'h0);
    expect_req("lbu", 32'h1000, 4'h8, 4'h0, 32'h0);
    respond(2, 32'h80112233);
    take_cdb("lbu", 0);

    send(1'b0, LH, 32'h1000, 32'h0, 32'd2, 4'd4);
    push(4'd4, 32'hFFFF8011, 32'h1000, 4'hC, 4'h0, 32'h80112233, 32'h0);
    expect_req("lh", 32'h1000, 4'hC, 4'h0, 32'h0);
    respond(1, 32'h80112233);
    take_cdb("lh", 0);

    send(1'b0, LHU, 32'h1000, 32'h0, 32'd2, 4'd9);
    push(4'd9, 32'h00008011, 32'h1000, 4'hC, 4'h0, 32'h80112233, 32'h0);
    expect_req("lhu", 32'h1000, 4'hC, 4'h0, 32'h0);
    respond(1, 32'h80112233);
    take_cdb("lhu", 0);

    send(1'b0, LB, 32'h1000, 32'h0, 32'd1, 4'd10);
    push(4'd10, 32'h00000022, 32'h1000, 4'h2, 4'h0, 32'h80112233, 32'h0);
    expect_req("lb1", 32'h1000, 4'h2, 4'h0, 32'h0);
    respond(1, 32'h80112233);
    take_cdb("lb1", 0);

    // halfword store waits for ROB head
    head = 4'd3;
    send(1'b1, SH, 32'h2000, 32'h0000ABCD, 32'd2, 4'd5);
    for (int i = 0; i < 4; i++) begin
      chk("sh_wait_wmask", 32'(dmem_wmask), 32'd0);
      chk("sh_wait_bp", 32'(bp), 32'd1);
      step();
    end
    head = 4'd5;
    push(4'd5, 32'h0, 32'h2000, 4'h0, 4'hC, 32'h0, 32'hABCD0000);
    expect_req("sh", 32'h2000, 4'h0, 4'hC, 32'hABCD0000);
    respond(2, 32'h0);
    take_cdb("sh", 0);

    // word store already at head
    head = 4'd2;
    send(1'b1, SW, 32'h2000, 32'h12345678, 32'h10, 4'd2);
    push(4'd2, 32'h0, 32'h2010, 4'h0, 4'hF, 32'h0, 32'h12345678);
    expect_req("sw", 32'h2010, 4'h0, 4'hF, 32'h12345678);
    respond(1, 32'h0);
    take_cdb("sw", 0);

    // flush while the load is outstanding
    send(1'b0, LW, 32'h1000, 32'h0, 32'h20, 4'd11);
    expect_req("fl_rw", 32'h1020, 4'hF, 4'h0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("fl_rw_bp", 32'(bp), 32'd1);
      chk("fl_rw_req", 32'(cdb_req), 32'd0);
      step();
    end
    respond(1, 32'h11111111);
    chk("fl_rw_bp_done", 32'(bp), 32'd0);
    chk("fl_rw_no_cdb", 32'(cdb_req), 32'd0);

    // ack withheld; a waiting packet is taken one cycle after ack
    send(1'b0, LW, 32'h1000, 32'h0, 32'h40, 4'd6);
    push(4'd6, 32'hCAFEF00D, 32'h1040, 4'hF, 4'h0, 32'hCAFEF00D, 32'h0);
    expect_req("hold", 32'h1040, 4'hF, 4'h0, 32'h0);
    respond(1, 32'hCAFEF00D);
    present(1'b0, LW, 32'h3000, 32'h0, 32'd4, 4'd7);
    take_cdb("hold", 4);
    chk("hold_not_early", 32'(dmem_rmask), 32'd0);
    step();
    pkt.valid = 1'b0;
    chk("hold_next_rmask", 32'(dmem_rmask), 32'hF);
    chk("hold_next_addr", dmem_addr, 32'h3004);
    push(4'd7, 32'h01020304, 32'h3004, 4'hF, 4'h0, 32'h01020304, 32'h0);
    expect_req("next", 32'h3004, 4'hF, 4'h0, 32'h0);
    respond(2, 32'h01020304);
    take_cdb("next", 0);

    // flush in ST_WAIT
    head = 4'd3;
    send(1'b1, SB, 32'h2000, 32'h55, 32'd1, 4'd12);
    step();
    chk("fl_sw_bp", 32'(bp), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    head = 4'd12;
    for (int i = 0; i < 3; i++) begin
      chk("fl_sw_idle", 32'(bp), 32'd0);
      chk("fl_sw_nowr", 32'(dmem_wmask), 32'd0);
      step();
    end

    // flush alongside a valid packet
    present(1'b0, LW, 32'h1000, 32'h0, 32'd0, 4'd8);
    flush = 1'b1;
    step();
    flush = 1'b0;
    pkt.valid = 1'b0;
    chk("fl_acc_bp", 32'(bp), 32'd0);
    chk("fl_acc_rmask", 32'(dmem_rmask), 32'd0);

    // flush in RESULT
    send(1'b0, LW, 32'h1000, 32'h0, 32'd4, 4'd13);
    expect_req("fl_res", 32'h1004, 4'hF, 4'h0, 32'h0);
    respond(1, 32'h22222222);
    chk("fl_res_req", 32'(cdb_req), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_res_req_drop", 32'(cdb_req), 32'd0);
    chk("fl_res_bp", 32'(bp), 32'd0);

    // stray resp/ack in IDLE
    dmem_resp = 1'b1;
    cdb_ack   = 1'b1;
    step();
    dmem_resp = 1'b0;
    cdb_ack   = 1'b0;
    chk("stray_bp", 32'(bp), 32'd0);
    chk("stray_req", 32'(cdb_req), 32'd0);

    // ack held high before RESULT has no effect
    cdb_ack = 1'b1;
    send(1'b0, LW, 32'h1000, 32'h0, 32'h80, 4'd14);
    expect_req("early_ack", 32'h1080, 4'hF, 4'h0, 32'h0);
    chk("early_ack_bp", 32'(bp), 32'd1);
    cdb_ack = 1'b0;
    push(4'd14, 32'h33334444, 32'h1080, 4'hF, 4'h0, 32'h33334444, 32'h0);
    respond(1, 32'h33334444);
    take_cdb("early_ack", 0);

    // reset mid-operation
    send(1'b0, LW, 32'h1000, 32'h0, 32'h0, 4'd15);
    expect_req("rst_mid", 32'h1000, 4'hF, 4'h0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_bp", 32'(bp), 32'd0);
    step();
    chk("rst_mid_req", 32'(cdb_req), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
